// File: rtl/maxpool_flat.sv
// 2x2 max-pooling over two 64x64 layer-0 channels: four reads per window, then
// the max goes to the per-channel layer-1 map and the channel-interleaved layer-2 map.
module maxpool_flat (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        crd,
  output logic [11:0] caddr_rd,
  input  logic [19:0] cdata_rd,
  output logic        cwr,
  output logic [11:0] caddr_wr,
  output logic [19:0] cdata_wr,
  output logic [2:0]  csel
);
  typedef enum logic [2:0] {IDLE, RD, WAIT, WL1, WL2, FIN} state_t;

  state_t             state;
  logic               ch;
  logic [9:0]         w;
  logic [1:0]         k;
  logic signed [19:0] max_q;
  logic signed [19:0] din;
  logic signed [19:0] cand;

  // Window origin {r,0,c,0}; read index bit1 selects the lower row, bit0 the right column.
  function automatic logic [11:0] rd_addr(input logic [9:0] win, input logic [1:0] idx);
    return {win[9:5], idx[1], win[4:0], idx[0]};
  endfunction

  // Read data lags crd by one cycle: TL lands in RD k==1, BR lands in WAIT.
  always_comb begin
    din  = $signed(cdata_rd);
    cand = max_q;
    if (state == RD && k == 2'd1) cand = din;
    else if (din > max_q)         cand = din;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      ch       <= 1'b0;
      w        <= 10'd0;
      k        <= 2'd0;
      max_q    <= 20'sd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      crd      <= 1'b0;
      caddr_rd <= 12'd0;
      cwr      <= 1'b0;
      caddr_wr <= 12'd0;
      cdata_wr <= 20'd0;
      csel     <= 3'b000;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state    <= RD;
          busy     <= 1'b1;
          crd      <= 1'b1;
          k        <= 2'd0;
          caddr_rd <= rd_addr(w, 2'd0);
          csel     <= ch ? 3'b010 : 3'b001;
        end
        RD: begin
          if (k != 2'd0) max_q <= cand;
          k <= k + 2'd1;
          if (k == 2'd3) begin
            state <= WAIT;
            crd   <= 1'b0;
            csel  <= 3'b000;
          end else begin
            caddr_rd <= rd_addr(w, k + 2'd1);
          end
        end
        WAIT: begin
          max_q    <= cand;
          state    <= WL1;
          cwr      <= 1'b1;
          caddr_wr <= {2'b00, w};
          cdata_wr <= cand;
          csel     <= ch ? 3'b100 : 3'b011;
        end
        WL1: begin
          state    <= WL2;
          caddr_wr <= {1'b0, w, ch};
          csel     <= 3'b101;
        end
        WL2: begin
          cwr <= 1'b0;
          if (ch && (&w)) begin
            state <= FIN;
            done  <= 1'b1;
            busy  <= 1'b0;
            csel  <= 3'b000;
            ch    <= 1'b0;
            w     <= 10'd0;
          end else begin
            // Window counter wraps 1023->0 exactly when moving from ch0 to ch1.
            state    <= RD;
            crd      <= 1'b1;
            k        <= 2'd0;
            w        <= w + 10'd1;
            ch       <= ch | (&w);
            caddr_rd <= rd_addr(w + 10'd1, 2'd0);
            csel     <= (ch | (&w)) ? 3'b010 : 3'b001;
          end
        end
        FIN: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_maxpool_flat.sv
// Bench for maxpool_flat: L0 memory model, access logs, and a 2x2-block max reference.
module tb_maxpool_flat;
  logic        clk = 1'b0;
  logic        reset, start;
  logic        busy, done, crd, cwr;
  logic [11:0] caddr_rd, caddr_wr;
  logic [19:0] cdata_rd, cdata_wr;
  logic [2:0]  csel;

  maxpool_flat dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .crd(crd), .caddr_rd(caddr_rd), .cdata_rd(cdata_rd),
    .cwr(cwr), .caddr_wr(caddr_wr), .cdata_wr(cdata_wr), .csel(csel)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic signed [19:0] mem0 [4096];
  logic signed [19:0] mem1 [4096];

  // Data appears the cycle after crd; junk otherwise so mistimed sampling shows up.
  always @(posedge clk)
    cdata_rd <= crd ? (csel == 3'b010 ? mem1[caddr_rd] : mem0[caddr_rd]) : 20'($urandom);

  typedef struct packed {logic [11:0] a; logic [19:0] d; logic [2:0] s; logic [31:0] t;} acc_t;
  acc_t rd_q[$];
  acc_t wr_q[$];
  int   n_overlap = 0, done_cnt = 0;
  logic [31:0] done_t = 0;
  logic busy_at_done = 0, busy_before_done = 0, busy_prev = 0;

  always @(negedge clk) begin
    if (crd) rd_q.push_back('{caddr_rd, 20'd0, csel, cyc});
    if (cwr) wr_q.push_back('{caddr_wr, cdata_wr, csel, cyc});
    if (crd && cwr) n_overlap <= n_overlap + 1;
    if (done) begin
      done_cnt         <= done_cnt + 1;
      done_t           <= cyc;
      busy_at_done     <= busy;
      busy_before_done <= busy_prev;
    end
    busy_prev <= busy;
  end

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  typedef struct {logic signed [19:0] d0, d1, d2, d3, exp;} vec_t;
  vec_t tbl[8];

  function automatic logic signed [19:0] pix(input int ch, input int row, input int col);
    return (ch != 0) ? mem1[row*64 + col] : mem0[row*64 + col];
  endfunction

  function automatic logic signed [19:0] ref_max(input int ch, input int w);
    logic signed [19:0] m;
    int r, c;
    r = w / 32;
    c = w % 32;
    m = pix(ch, 2*r, 2*c);
    for (int dr = 0; dr < 2; dr++)
      for (int dc = 0; dc < 2; dc++)
        if (pix(ch, 2*r + dr, 2*c + dc) > m) m = pix(ch, 2*r + dr, 2*c + dc);
    return m;
  endfunction

  task automatic set_win(input int ch, input int w, input vec_t v);
    int b;
    b = (w / 32) * 128 + (w % 32) * 2;
    if (ch == 0) begin
      mem0[b] = v.d0; mem0[b+1] = v.d1; mem0[b+64] = v.d2; mem0[b+65] = v.d3;
    end else begin
      mem1[b] = v.d0; mem1[b+1] = v.d1; mem1[b+64] = v.d2; mem1[b+65] = v.d3;
    end
  endtask

  task automatic fill_random();
    for (int a = 0; a < 4096; a++) begin
      mem0[a] = 20'($urandom);
      mem1[a] = 20'($urandom);
    end
  endtask

  task automatic clear_logs();
    rd_q.delete();
    wr_q.delete();
    n_overlap = 0;
    done_cnt  = 0;
  endtask

  // Pulses start at a negedge; returns the first RD cycle.
  task automatic start_job(input string tag, output logic [31:0] t0);
    chk({tag, " busy before start"}, busy, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t0 = cyc;
    chk({tag, " busy rises after start"}, busy, 1);
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (done_cnt == 0 && n < 16000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " done seen within bound"}, done_cnt > 0, 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_job(input string tag, input logic [31:0] t0);
    int e_rd, e_l1, e_l2, j, n1, n2, idx, a, w;
    logic [31:0] base;
    logic signed [19:0] m;
    acc_t x1, x2;
    e_rd = 0; e_l1 = 0; e_l2 = 0; j = 0; n1 = 0; n2 = 0;
    chk({tag, " read count"}, rd_q.size(), 8192);
    chk({tag, " write count"}, wr_q.size(), 4096);
    for (int ch = 0; ch < 2; ch++)
      for (int r = 0; r < 32; r++)
        for (int c = 0; c < 32; c++) begin
          w = r*32 + c;
          base = t0 + 7*j;
          m = ref_max(ch, w);
          for (int q = 0; q < 4; q++) begin
            idx = 4*j + q;
            a = (2*r + q/2) * 64 + 2*c + q%2;
            if (idx >= rd_q.size()) e_rd++;
            else if (rd_q[idx].a != 12'(a) || rd_q[idx].s != (ch != 0 ? 3'b010 : 3'b001) ||
                     rd_q[idx].t != base + 32'(q)) e_rd++;
          end
          if (2*j + 1 < wr_q.size()) begin
            x1 = wr_q[2*j];
            x2 = wr_q[2*j + 1];
            if (x1.a != 12'(w) || x1.s != (ch != 0 ? 3'b100 : 3'b011) ||
                $signed(x1.d) != m || x1.t != base + 5) e_l1++;
            if (x2.a != 12'(2*w + ch) || x2.s != 3'b101 ||
                $signed(x2.d) != m || x2.t != base + 6) e_l2++;
          end else begin
            e_l1++;
            e_l2++;
          end
          j++;
        end
    foreach (wr_q[i]) begin
      if (wr_q[i].s == 3'b011 || wr_q[i].s == 3'b100) n1++;
      if (wr_q[i].s == 3'b101) n2++;
    end
    chk({tag, " read sequence errors"}, e_rd, 0);
    chk({tag, " L1 write errors"}, e_l1, 0);
    chk({tag, " L2 vs reference errors"}, e_l2, 0);
    chk({tag, " L1 writes"}, n1, 2048);
    chk({tag, " L2 writes"}, n2, 2048);
    chk({tag, " read/write overlap"}, n_overlap, 0);
    chk({tag, " done pulses"}, done_cnt, 1);
    chk({tag, " busy low at done"}, busy_at_done, 0);
    chk({tag, " busy high before done"}, busy_before_done, 1);
    if (wr_q.size() > 0) begin
      chk({tag, " job length"}, wr_q[$].t - t0 + 1, 14336);
      chk({tag, " done after last write"}, done_t, wr_q[$].t + 1);
    end
    if (rd_q.size() == 8192) begin
      chk({tag, " last reads TL"}, rd_q[8188].a, 4030);
      chk({tag, " last reads TR"}, rd_q[8189].a, 4031);
      chk({tag, " last reads BL"}, rd_q[8190].a, 4094);
      chk({tag, " last reads BR"}, rd_q[8191].a, 4095);
      chk({tag, " last reads csel"}, rd_q[8191].s, 2);
      chk({tag, " first read addr"}, rd_q[0].a, 0);
      chk({tag, " first read csel"}, rd_q[0].s, 1);
    end
    if (wr_q.size() == 4096) begin
      chk({tag, " last L1 addr"}, wr_q[4094].a, 1023);
      chk({tag, " last L1 csel"}, wr_q[4094].s, 4);
      chk({tag, " last L2 addr"}, wr_q[4095].a, 2047);
    end
    chk({tag, " idle busy"}, busy, 0);
    chk({tag, " idle crd/cwr/csel"}, {crd, cwr, csel}, 0);
  endtask

  logic [31:0] t0;
  int nw, nr, n;
  logic found;

  initial begin
    tbl[0] = '{20'sd5, 20'sd9, 20'sd3, 20'sd7, 20'sd9};
    tbl[1] = '{-20'sd4, -20'sd2, -20'sd2, -20'sd8, -20'sd2};
    tbl[2] = '{20'sd0, 20'sd0, 20'sd0, 20'sd0, 20'sd0};
    tbl[3] = '{20'sh80000, 20'sh80000, 20'sh80000, 20'sh80000, 20'sh80000};
    tbl[4] = '{20'sh80000, 20'sh7FFFF, 20'sd0, -20'sd1, 20'sh7FFFF};
    tbl[5] = '{-20'sd1, -20'sd5, -20'sd3, -20'sd2, -20'sd1};
    tbl[6] = '{-20'sd10, -20'sd20, -20'sd30, -20'sd7, -20'sd7};
    tbl[7] = '{20'sd100, 20'sh80000, 20'sd99, 20'sd100, 20'sd100};

    reset = 1'b0;
    start = 1'b0;
    fill_random();
    foreach (tbl[i]) set_win(0, i, tbl[i]);
    set_win(1, 1023, tbl[1]);
    #2 reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset crd", crd, 0);
    chk("reset cwr", cwr, 0);
    chk("reset caddr_rd", caddr_rd, 0);
    chk("reset caddr_wr", caddr_wr, 0);
    chk("reset cdata_wr", cdata_wr, 0);
    chk("reset csel", csel, 0);
    reset = 1'b0;
    @(negedge clk);

    // Job 1: table windows plus random data, with a stray start mid-job.
    clear_logs();
    start_job("job1", t0);
    repeat (99) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("job1");
    check_job("job1", t0);
    if (wr_q.size() == 4096) begin
      foreach (tbl[i]) chk($sformatf("table win %0d L1 max", i), $signed(wr_q[2*i].d), tbl[i].exp);
      chk("win0 L1 addr", wr_q[0].a, 0);
      chk("win0 L1 csel", wr_q[0].s, 3);
      chk("win0 L1 cycle offset", wr_q[0].t - t0, 5);
      chk("win0 L2 data", $signed(wr_q[1].d), 9);
      chk("win0 L2 csel", wr_q[1].s, 5);
      chk("ch1 win1023 L1 max", $signed(wr_q[4094].d), -2);
      chk("ch1 win1023 L2 max", $signed(wr_q[4095].d), -2);
    end

    // Job 2: reset during the ch0 window 10 L1 write.
    clear_logs();
    start_job("job2", t0);
    found = 1'b0;
    n = 0;
    while (!found && n < 200) begin
      @(negedge clk);
      n++;
      if (cwr && csel == 3'b011 && caddr_wr == 12'd10) found = 1'b1;
    end
    chk("abort trigger reached", found, 1);
    #1 reset = 1'b1;
    #1 chk("abort outputs cleared", {busy, done, crd, cwr, caddr_rd, caddr_wr, cdata_wr, csel}, 0);
    nw = wr_q.size();
    nr = rd_q.size();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    chk("abort no further writes", wr_q.size(), nw);
    chk("abort no further reads", rd_q.size(), nr);
    chk("abort stays idle", busy, 0);

    // Job 3: fresh random data, must restart from ch0 window 0.
    fill_random();
    clear_logs();
    start_job("job3", t0);
    chk("job3 restart addr", caddr_rd, 0);
    chk("job3 restart csel", csel, 1);
    wait_done("job3");
    check_job("job3", t0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
